mem_resp_demux2: RTL and testbench

Registered 1-to-2 response demultiplexer for the shared memory port of the dual-core machine. Requests from core 0 and core 1 are merged onto one memory port upstream. This block records, in issue order, which core owned each accepted request. It then routes each in-order memory response back to the owning core through a one-entry valid/ready output register per core.

---
 rtl/mem_pkg.sv | 9 +
 rtl/tag_fifo.sv | 50 +++++
 rtl/mem_resp_demux2.sv | 86 ++++++++
 tb/tb_mem_resp_demux2.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the dual-core memory response path.
package mem_pkg;
  typedef logic core_id_t;

  localparam core_id_t CORE0 = 1'b0;
  localparam core_id_t CORE1 = 1'b1;

  localparam int unsigned MEM_OUTSTANDING = 4;
endpackage

// File: rtl/tag_fifo.sv
// Generic synchronous FIFO with registered pointers and an occupancy count
// one bit wider than the pointers so full and empty stay distinct.
module tag_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [W-1:0]            din,
  input  logic                    pop,
  output logic [W-1:0]            head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy state; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mem_resp_demux2.sv
// Routes in-order memory responses back to the owning core using an order
// FIFO of owner tags and one valid/ready output register per core.
module mem_resp_demux2
  import mem_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = MEM_OUTSTANDING
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    issue_sel,
  output logic                    issue_ready,
  input  logic                    resp_valid,
  input  logic [N-1:0]            resp_data,
  output logic                    resp_ready,
  output logic                    out0_valid,
  output logic [N-1:0]            out0_data,
  input  logic                    out0_ready,
  output logic                    out1_valid,
  output logic [N-1:0]            out1_data,
  input  logic                    out1_ready,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    err_unexpected
);
  core_id_t head_tag;
  logic     fifo_full;
  logic     fifo_empty;
  logic     head_valid;
  logic     head_ready;
  logic     route;
  logic     route0;
  logic     route1;
  logic     unexpected;

  tag_fifo #(
    .W     (1),
    .DEPTH (DEPTH)
  ) u_order (
    .clk   (clk),
    .reset (reset),
    .push  (issue_valid && issue_ready),
    .din   (issue_sel),
    .pop   (route),
    .head  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // Ready depends only on state and core readies, never on resp_valid.
  assign issue_ready = !fifo_full;
  assign head_valid  = (head_tag == CORE1) ? out1_valid : out0_valid;
  assign head_ready  = (head_tag == CORE1) ? out1_ready : out0_ready;
  assign resp_ready  = fifo_empty || !head_valid || head_ready;

  assign route      = resp_valid && resp_ready && !fifo_empty;
  assign route0     = route && (head_tag == CORE0);
  assign route1     = route && (head_tag == CORE1);
  assign unexpected = resp_valid && fifo_empty;

  // Output holding registers: a new route wins over a same-cycle drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out0_valid     <= 1'b0;
      out0_data      <= '0;
      out1_valid     <= 1'b0;
      out1_data      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (route0) begin
        out0_valid <= 1'b1;
        out0_data  <= resp_data;
      end else if (out0_ready) begin
        out0_valid <= 1'b0;
      end
      if (route1) begin
        out1_valid <= 1'b1;
        out1_data  <= resp_data;
      end else if (out1_ready) begin
        out1_valid <= 1'b0;
      end
      err_unexpected <= unexpected;
    end
  end
endmodule

// File: tb/tb_mem_resp_demux2.sv
// Self-checking bench for mem_resp_demux2: directed tables and sequences plus
// randomized traffic, all checked against a queue-based reference model.
module tb_mem_resp_demux2;
  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   issue_valid;
  logic                   issue_sel;
  logic                   issue_ready;
  logic                   resp_valid;
  logic [N-1:0]           resp_data;
  logic                   resp_ready;
  logic                   out0_valid;
  logic [N-1:0]           out0_data;
  logic                   out0_ready;
  logic                   out1_valid;
  logic [N-1:0]           out1_data;
  logic                   out1_ready;
  logic [$clog2(DEPTH):0] outstanding;
  logic                   err_unexpected;

  always #5 clk = ~clk;

  mem_resp_demux2 #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_sel      (issue_sel),
    .issue_ready    (issue_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_ready     (resp_ready),
    .out0_valid     (out0_valid),
    .out0_data      (out0_data),
    .out0_ready     (out0_ready),
    .out1_valid     (out1_valid),
    .out1_data      (out1_data),
    .out1_ready     (out1_ready),
    .outstanding    (outstanding),
    .err_unexpected (err_unexpected)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: owner queue, per-core held response, pending error pulse.
  bit           tq[$];
  logic         mv[2];
  logic [N-1:0] md[2];
  logic         merr;

  typedef struct {
    logic         iv;
    logic         is;
    logic         rv;
    logic [N-1:0] rd;
    logic         e0v;
    logic [N-1:0] e0d;
    logic         e1v;
    logic [N-1:0] e1d;
    int           eo;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    tq.delete();
    mv[0] = 1'b0; mv[1] = 1'b0;
    md[0] = '0;   md[1] = '0;
    merr  = 1'b0;
  endtask

  // One clock cycle: drive, check handshakes, advance model, check registers.
  task automatic cyc(input logic iv, input logic is, input logic rv,
                     input logic [N-1:0] rd, input logic r0, input logic r1);
    logic emp, h, rr, ir, rt;
    logic rdy[2];
    issue_valid = iv; issue_sel = is; resp_valid = rv; resp_data = rd;
    out0_ready = r0; out1_ready = r1;
    #1;
    emp = (tq.size() == 0);
    h   = emp ? 1'b0 : tq[0];
    rdy[0] = r0; rdy[1] = r1;
    rr  = emp || !mv[h] || rdy[h];
    ir  = (tq.size() < DEPTH);
    chk("resp_ready", N'(resp_ready), N'(rr));
    chk("issue_ready", N'(issue_ready), N'(ir));
    rt = rv && rr && !emp;
    for (int c = 0; c < 2; c++) if (mv[c] && rdy[c]) mv[c] = 1'b0;
    if (rt) begin
      mv[h] = 1'b1;
      md[h] = rd;
      void'(tq.pop_front());
    end
    if (iv && ir) tq.push_back(is);
    merr = rv && emp;
    @(posedge clk); #1;
    chk("out0_valid", N'(out0_valid), N'(mv[0]));
    chk("out0_data", out0_data, md[0]);
    chk("out1_valid", N'(out1_valid), N'(mv[1]));
    chk("out1_data", out1_data, md[1]);
    chk("outstanding", N'(outstanding), N'(tq.size()));
    chk("err_unexpected", N'(err_unexpected), N'(merr));
  endtask

  // Raise reset mid-cycle and check that state clears without a clock edge.
  task automatic do_reset();
    issue_valid = 1'b0; resp_valid = 1'b0; resp_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_out0_valid", N'(out0_valid), N'(1'b0));
    chk("rst_out1_valid", N'(out1_valid), N'(1'b0));
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
    chk("rst_outstanding", N'(outstanding), '0);
    chk("rst_err", N'(err_unexpected), '0);
    chk("rst_issue_ready", N'(issue_ready), N'(1'b1));
    chk("rst_resp_ready", N'(resp_ready), N'(1'b1));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_sel = 1'b0; resp_valid = 1'b0; resp_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // In-order routing with both cores ready.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        2};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        3};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA, 1'b0, 32'h0,        2};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'hBBBBBBBB, 1'b0, 32'hAAAAAAAA, 1'b1, 32'hBBBBBBBB, 1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'hCCCCCCCC, 1'b1, 32'hCCCCCCCC, 1'b0, 32'hBBBBBBBB, 0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'hCCCCCCCC, 1'b0, 32'hBBBBBBBB, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].iv, tbl[i].is, tbl[i].rv, tbl[i].rd, 1'b1, 1'b1);
      chk("tbl_out0_valid", N'(out0_valid), N'(tbl[i].e0v));
      chk("tbl_out0_data", out0_data, tbl[i].e0d);
      chk("tbl_out1_valid", N'(out1_valid), N'(tbl[i].e1v));
      chk("tbl_out1_data", out1_data, tbl[i].e1d);
      chk("tbl_outstanding", N'(outstanding), N'(tbl[i].eo));
    end

    // Backpressure on core 1.
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b0);
      chk("bp_hold_valid", N'(out1_valid), N'(1'b1));
      chk("bp_hold_data", out1_data, 32'h11111111);
      chk("bp_hold_outstanding", N'(outstanding), N'(1));
      chk("bp_stall_ready", N'(resp_ready), N'(1'b0));
    end
    cyc(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1, 1'b1);
    chk("bp_swap_valid", N'(out1_valid), N'(1'b1));
    chk("bp_swap_data", out1_data, 32'h22222222);
    chk("bp_swap_outstanding", N'(outstanding), '0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("bp_drained", N'(out1_valid), N'(1'b0));

    // Fill the order FIFO, then overflow attempt, then one pop.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom_range(1)), 1'b0, '0, 1'b1, 1'b1);
    chk("full_outstanding", N'(outstanding), N'(4));
    chk("full_issue_ready", N'(issue_ready), N'(1'b0));
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("full_ignored", N'(outstanding), N'(4));
    cyc(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b1, 1'b1);
    chk("full_pop_outstanding", N'(outstanding), N'(3));
    chk("full_pop_issue_ready", N'(issue_ready), N'(1'b1));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Response with nothing outstanding.
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    chk("unexp_err_pulse", N'(err_unexpected), N'(1'b1));
    chk("unexp_out0", N'(out0_valid), N'(1'b0));
    chk("unexp_out1", N'(out1_valid), N'(1'b0));
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("unexp_err_clear", N'(err_unexpected), N'(1'b0));

    // Simultaneous push and pop across pointer wrap.
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'($urandom_range(1)), 1'b1, $urandom, 1'b1, 1'b1);
      chk("wrap_outstanding", N'(outstanding), N'(1));
    end
    cyc(1'b0, 1'b0, 1'b1, $urandom, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(2) != 0),
          $urandom, 1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0));
    end

    // Reset in the middle of traffic with a held response.
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h55555555, 1'b1, 1'b1);
    chk("post_rst_route", out1_data, 32'h55555555);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
